fir_parallel_l: RTL and testbench
=================================

FIR_PARALLEL_L -- requirements
Module: fir_parallel_l

Interface
REQ-001 The block SHALL have parameter L, default 2, meaning parallel lanes (samples per block), legal 1..4.
REQ-002 The block SHALL have parameter TAPS, default 8, meaning filter length, a multiple of L, 2..32.
REQ-003 The block SHALL have parameter DATA_W, default 24, meaning signed sample width.
REQ-004 The block SHALL have parameter COEF_W, default 24, meaning signed coefficient width.
REQ-005 The block SHALL have parameter ACC_W, default 48, meaning signed accumulator width.
REQ-006 The block SHALL have parameter OUT_SHIFT, default 0, meaning arithmetic right shift applied before output narrowing.
REQ-007 The block SHALL have port clk, input, 1, sole clock; all state changes on its rising edge.
REQ-008 The block SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-009 The block SHALL have port in_valid, input, 1, in_data carries one block of L new samples.
REQ-010 The block SHALL have port in_data, input, L*DATA_W, lane j at [j*DATA_W +: DATA_W]; lane 0 is the oldest sample.
REQ-011 The block SHALL have port flush, input, 1, synchronous clear of the delay line.
REQ-012 The block SHALL have port coef_we, input, 1, coefficient write strobe.
REQ-013 The block SHALL have port coef_addr, input, $clog2(TAPS), tap index k.
REQ-014 The block SHALL have port coef_data, input, COEF_W, signed value of h[k].
REQ-015 The block SHALL have port out_valid, output, 1, out_data, out_acc and out_sat hold a new block.
REQ-016 The block SHALL have port out_acc, output, L*ACC_W, full-precision lane sums, same lane order as in_data.
REQ-017 The block SHALL have port out_data, output, L*DATA_W, shifted and saturated lane outputs.
REQ-018 The block SHALL have port out_sat, output, L, per-lane saturation flag for the current block.

Function
REQ-019 Lane j of an accepted block SHALL compute y = sum over k=0..TAPS-1 of h[k]*x[n-k], where x[n] is that lane's sample and x[n-1] is lane j-1, or lane L-1 of the previous accepted block.
REQ-020 The delay line SHALL advance by L samples only on cycles with in_valid=1; cycles with in_valid=0 SHALL leave all state except out_valid unchanged.
REQ-021 Pipeline SHALL be two stages (registered products, then registered sums/outputs), giving out_valid=1 exactly 2 cycles after the accepting edge; throughput SHALL be one block per cycle with no bubbles.
REQ-022 Products SHALL be DATA_W+COEF_W signed, sign-extended to ACC_W; the sum SHALL wrap modulo 2^ACC_W.
REQ-023 out_data lane = (out_acc lane >>> OUT_SHIFT) saturated to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; out_sat lane SHALL be 1 when clipping occurred.
REQ-024 Outputs SHALL hold their last values while out_valid=0.
REQ-025 A coefficient write SHALL update h[coef_addr] at the edge and apply to blocks accepted on later edges; blocks already in the pipeline SHALL use the old value.
REQ-026 flush=1 SHALL zero all delay-line samples and squash in-flight out_valid; if in_valid=1 on the same edge, flush wins and the block is dropped (no out_valid).
REQ-027 Coefficient registers SHALL be unaffected by flush.
REQ-028 coef_we and in_valid on the same edge SHALL both take effect; that block SHALL use the old coefficient.

Reset
REQ-029 While reset=0: delay line, product registers, coefficients, out_acc, out_data and out_sat SHALL be 0, and out_valid SHALL be 0, immediately and without waiting for clk.
REQ-030 A reset asserted mid-stream SHALL discard all in-flight blocks; the first block accepted after release SHALL see zero history.

Verification (L=2, TAPS=8, OUT_SHIFT=0 unless stated)
REQ-031 Step: h[k]=1 for all k, blocks {1,1} every cycle -> out_acc lanes (1,2),(3,4),(5,6),(7,8), then (8,8) steady; out_valid first high 2 cycles after the first block.
REQ-032 Impulse: h[k]=k+1, one block {1,0} then {0,0} -> lane pairs (1,2),(3,4),(5,6),(7,8), then (0,0).
REQ-033 Gaps: impulse test with in_valid low for 3 cycles between blocks -> identical out_acc sequence, out_valid pulses only for accepted blocks.
REQ-034 Saturation: h[0]=2^23-1 with input 2^23-1 -> out_data=8388607 and out_sat=1 for that lane; with OUT_SHIFT=46 -> out_sat=0.
REQ-035 Flush and reset: assert flush mid-step (with in_valid=1), then assert reset=0 mid-step -> no out_valid for the dropped block, ramp restarts at (1,2), and all outputs read 0 during reset.
REQ-036 Coefficient update: write h[0]=5 on the same edge as a block -> that block uses the old h[0]; the following block uses 5.

Source files
------------

// File: rtl/fir_parallel_l.sv
// L-lane parallel FIR filter with runtime-writable coefficients.
// Two pipeline stages: registered tap products, then registered lane sums with shift/saturate.
module fir_parallel_l #(
  parameter int L         = 2,
  parameter int TAPS      = 8,
  parameter int DATA_W    = 24,
  parameter int COEF_W    = 24,
  parameter int ACC_W     = 48,
  parameter int OUT_SHIFT = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  input  logic [L*DATA_W-1:0]       in_data,
  input  logic                      flush,
  input  logic                      coef_we,
  input  logic [$clog2(TAPS)-1:0]   coef_addr,
  input  logic signed [COEF_W-1:0]  coef_data,
  output logic                      out_valid,
  output logic [L*ACC_W-1:0]        out_acc,
  output logic [L*DATA_W-1:0]       out_data,
  output logic [L-1:0]              out_sat
);

  localparam int PROD_W = DATA_W + COEF_W;
  localparam int HIST_N = TAPS - 1;
  localparam int WIN_N  = L + TAPS - 1;
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((longint'(1) <<< (DATA_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  logic signed [DATA_W-1:0] hist [HIST_N];
  logic signed [DATA_W-1:0] win  [WIN_N];
  logic signed [COEF_W-1:0] coef [TAPS];
  logic signed [PROD_W-1:0] prod [L][TAPS];
  logic                     v1;

  logic signed [ACC_W-1:0]  lane_sum [L];
  logic signed [ACC_W-1:0]  lane_shr [L];
  logic [DATA_W-1:0]        lane_dat [L];
  logic [L-1:0]             lane_clip;

  // Window ordered newest first: win[0] is lane L-1 of the incoming block,
  // win[L] onward is the stored history. Lane j, tap k reads win[L-1-j+k].
  always_comb begin
    for (int i = 0; i < L; i++) begin
      win[i] = in_data[(L-1-i)*DATA_W +: DATA_W];
    end
    for (int m = 0; m < HIST_N; m++) begin
      win[L+m] = hist[m];
    end
  end

  // NOTE: every variable written here gets a value before use on all paths, so no latch is inferred.
  always_comb begin
    lane_clip = '0;
    for (int j = 0; j < L; j++) begin
      lane_sum[j] = '0;
      for (int k = 0; k < TAPS; k++) begin
        lane_sum[j] = lane_sum[j] + ACC_W'(prod[j][k]);
      end
      lane_shr[j] = lane_sum[j] >>> OUT_SHIFT;
      if (lane_shr[j] > SAT_MAX) begin
        lane_dat[j]  = SAT_MAX[DATA_W-1:0];
        lane_clip[j] = 1'b1;
      end else if (lane_shr[j] < SAT_MIN) begin
        lane_dat[j]  = SAT_MIN[DATA_W-1:0];
        lane_clip[j] = 1'b1;
      end else begin
        lane_dat[j]  = lane_shr[j][DATA_W-1:0];
      end
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values,
  // and the coefficient file is reset too because it is architecturally visible state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int m = 0; m < HIST_N; m++) hist[m] <= '0;
      for (int k = 0; k < TAPS; k++)   coef[k] <= '0;
      for (int j = 0; j < L; j++) begin
        for (int k = 0; k < TAPS; k++) prod[j][k] <= '0;
      end
      v1        <= 1'b0;
      out_valid <= 1'b0;
      out_acc   <= '0;
      out_data  <= '0;
      out_sat   <= '0;
    end else begin
      // Products below read coef before this write lands, so same-edge blocks see the old value.
      if (coef_we && int'(coef_addr) < TAPS) begin
        coef[coef_addr] <= coef_data;
      end

      out_valid <= v1 && !flush;
      if (v1 && !flush) begin
        for (int j = 0; j < L; j++) begin
          out_acc[j*ACC_W +: ACC_W]   <= lane_sum[j];
          out_data[j*DATA_W +: DATA_W] <= lane_dat[j];
        end
        out_sat <= lane_clip;
      end

      if (flush) begin
        for (int m = 0; m < HIST_N; m++) hist[m] <= '0;
        v1 <= 1'b0;
      end else begin
        v1 <= in_valid;
        if (in_valid) begin
          for (int m = 0; m < HIST_N; m++) hist[m] <= win[m];
          for (int j = 0; j < L; j++) begin
            for (int k = 0; k < TAPS; k++) begin
              prod[j][k] <= PROD_W'(win[L-1-j+k]) * PROD_W'(coef[k]);
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_fir_parallel_l.sv
// Scoreboard bench for fir_parallel_l: a sample-history model computes each lane's
// convolution directly; a negedge monitor pops and compares whenever out_valid is high.
module tb_fir_parallel_l;

  localparam int L      = 2;
  localparam int TAPS   = 8;
  localparam int DATA_W = 24;
  localparam int COEF_W = 24;
  localparam int ACC_W  = 48;
  localparam int AW     = $clog2(TAPS);
  localparam int SH_B   = 46;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   in_valid;
  logic [L*DATA_W-1:0]    in_data;
  logic                   flush;
  logic                   coef_we;
  logic [AW-1:0]          coef_addr;
  logic [COEF_W-1:0]      coef_data;

  logic                   a_valid, b_valid;
  logic [L*ACC_W-1:0]     a_acc, b_acc;
  logic [L*DATA_W-1:0]    a_data, b_data;
  logic [L-1:0]           a_sat, b_sat;

  fir_parallel_l #(.L(L), .TAPS(TAPS), .DATA_W(DATA_W), .COEF_W(COEF_W),
                   .ACC_W(ACC_W), .OUT_SHIFT(0)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .flush(flush),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .out_valid(a_valid), .out_acc(a_acc), .out_data(a_data), .out_sat(a_sat));

  fir_parallel_l #(.L(L), .TAPS(TAPS), .DATA_W(DATA_W), .COEF_W(COEF_W),
                   .ACC_W(ACC_W), .OUT_SHIFT(SH_B)) u_dut_sh (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .flush(flush),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .out_valid(b_valid), .out_acc(b_acc), .out_data(b_data), .out_sat(b_sat));

  always #5 clk = ~clk;

  typedef struct {
    logic [L-1:0][63:0] acc;
    logic [L-1:0][63:0] d0;
    logic [L-1:0][63:0] d1;
    logic [L-1:0]       s0;
    logic [L-1:0]       s1;
    int                 n;
  } exp_t;

  exp_t   q[$];
  longint xs[$];
  longint h [TAPS];
  int     ncyc = 0;
  int     n_checks = 0;
  int     n_fail = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint sext(input longint v, input int w);
    longint r;
    r = v <<< (64 - w);
    return r >>> (64 - w);
  endfunction

  function automatic void saturate(input longint acc, input int sh,
                                   output longint d, output logic s);
    longint v, mx, mn;
    v  = acc >>> sh;
    mx = (longint'(1) <<< (DATA_W - 1)) - 1;
    mn = -mx - 1;
    s  = 1'b0;
    d  = v;
    if (v > mx) begin d = mx; s = 1'b1; end
    else if (v < mn) begin d = mn; s = 1'b1; end
  endfunction

  function automatic logic [L*DATA_W-1:0] pack(input longint a, input longint b);
    logic [L*DATA_W-1:0] r;
    r = '0;
    r[0 +: DATA_W]      = DATA_W'(a);
    r[DATA_W +: DATA_W] = DATA_W'(b);
    return r;
  endfunction

  task automatic model_reset();
    q.delete();
    xs.delete();
    for (int k = 0; k < TAPS; k++) h[k] = 0;
  endtask

  // One clock of stimulus; the model is updated right after the edge that samples it.
  task automatic drive(input logic v, input logic [L*DATA_W-1:0] d, input logic fl,
                       input logic we, input int addr, input longint cd);
    exp_t e;
    in_valid  = v;
    in_data   = d;
    flush     = fl;
    coef_we   = we;
    coef_addr = AW'(addr);
    coef_data = COEF_W'(cd);
    @(posedge clk);
    if (fl) begin
      q.delete();
      xs.delete();
    end else if (v) begin
      for (int j = 0; j < L; j++) xs.push_back(sext(longint'(d[j*DATA_W +: DATA_W]), DATA_W));
      for (int j = 0; j < L; j++) begin
        longint s, a, dv;
        logic sv;
        int nidx;
        s = 0;
        nidx = xs.size() - L + j;
        for (int k = 0; k < TAPS; k++) begin
          if (nidx - k >= 0) s += h[k] * xs[nidx - k];
        end
        a = sext(s, ACC_W);
        e.acc[j] = a;
        saturate(a, 0, dv, sv);    e.d0[j] = dv; e.s0[j] = sv;
        saturate(a, SH_B, dv, sv); e.d1[j] = dv; e.s1[j] = sv;
      end
      e.n = ncyc;
      q.push_back(e);
      while (xs.size() > 4 * TAPS) void'(xs.pop_front());
    end
    if (we) h[addr] = sext(cd, COEF_W);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic wcoef(input int k, input longint v);
    drive(1'b0, '0, 1'b0, 1'b1, k, v);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, longint'(a_valid), 0);
    check({tag, "_acc"},   longint'(a_acc[63:0]) | longint'(a_acc[L*ACC_W-1:64]), 0);
    check({tag, "_data"},  longint'(a_data), 0);
    check({tag, "_sat"},   longint'(a_sat), 0);
    check({tag, "_sh_valid"}, longint'(b_valid), 0);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a block.
  always @(negedge clk) begin
    exp_t e;
    ncyc++;
    if (reset === 1'b1 && a_valid === 1'b1) begin
      n_checks++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_out_valid: got out_valid=1 expected no pending block at %0t", $time);
      end else begin
        e = q.pop_front();
        check("latency", longint'(ncyc - e.n), 2);
        check("sh_valid", longint'(b_valid), 1);
        for (int j = 0; j < L; j++) begin
          check($sformatf("acc_l%0d", j), sext(longint'(a_acc[j*ACC_W +: ACC_W]), ACC_W), longint'(e.acc[j]));
          check($sformatf("data_l%0d", j), sext(longint'(a_data[j*DATA_W +: DATA_W]), DATA_W), longint'(e.d0[j]));
          check($sformatf("sat_l%0d", j), longint'(a_sat[j]), longint'(e.s0[j]));
          check($sformatf("shdata_l%0d", j), sext(longint'(b_data[j*DATA_W +: DATA_W]), DATA_W), longint'(e.d1[j]));
          check($sformatf("shsat_l%0d", j), longint'(b_sat[j]), longint'(e.s1[j]));
        end
      end
    end
  end

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_data = '0; flush = 1'b0;
    coef_we = 1'b0; coef_addr = '0; coef_data = '0;
    model_reset();
    #3;
    check_zero("reset_init");
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // Step response with all-ones taps.
    for (int k = 0; k < TAPS; k++) wcoef(k, 1);
    for (int i = 0; i < 7; i++) drive(1'b1, pack(1, 1), 1'b0, 1'b0, 0, 0);
    idle(3);

    // Impulse with h[k]=k+1, back-to-back then with 3-cycle gaps.
    drive(1'b0, '0, 1'b1, 1'b0, 0, 0);
    for (int k = 0; k < TAPS; k++) wcoef(k, k + 1);
    drive(1'b1, pack(1, 0), 1'b0, 1'b0, 0, 0);
    for (int i = 0; i < 5; i++) drive(1'b1, pack(0, 0), 1'b0, 1'b0, 0, 0);
    idle(3);
    drive(1'b0, '0, 1'b1, 1'b0, 0, 0);
    drive(1'b1, pack(1, 0), 1'b0, 1'b0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      idle(3);
      drive(1'b1, pack(0, 0), 1'b0, 1'b0, 0, 0);
    end
    idle(3);

    // Saturation: h[0] = max positive, input = max positive on lane 0.
    drive(1'b0, '0, 1'b1, 1'b0, 0, 0);
    for (int k = 1; k < TAPS; k++) wcoef(k, 0);
    wcoef(0, 8388607);
    drive(1'b1, pack(8388607, 0), 1'b0, 1'b0, 0, 0);
    drive(1'b1, pack(-8388608, 8388607), 1'b0, 1'b0, 0, 0);
    idle(3);
    check("sat_hold_data", sext(longint'(a_data[DATA_W +: DATA_W]), DATA_W), 8388607);

    // Flush mid-step with in_valid high, then reset mid-step.
    drive(1'b0, '0, 1'b1, 1'b0, 0, 0);
    for (int k = 0; k < TAPS; k++) wcoef(k, 1);
    for (int i = 0; i < 3; i++) drive(1'b1, pack(1, 1), 1'b0, 1'b0, 0, 0);
    drive(1'b1, pack(1, 1), 1'b1, 1'b0, 0, 0);
    for (int i = 0; i < 4; i++) drive(1'b1, pack(1, 1), 1'b0, 1'b0, 0, 0);
    reset = 1'b0;
    model_reset();
    #1;
    check_zero("reset_mid");
    @(posedge clk);
    #1 reset = 1'b1;
    for (int k = 0; k < TAPS; k++) wcoef(k, 1);
    for (int i = 0; i < 5; i++) drive(1'b1, pack(1, 1), 1'b0, 1'b0, 0, 0);
    idle(3);

    // Coefficient write on the same edge as a block.
    drive(1'b0, '0, 1'b1, 1'b0, 0, 0);
    drive(1'b1, pack(1, 2), 1'b0, 1'b1, 0, 5);
    drive(1'b1, pack(3, 4), 1'b0, 1'b0, 0, 0);
    idle(3);

    // Randomized traffic with occasional flushes and coefficient writes.
    for (int i = 0; i < 1500; i++) begin
      logic v, fl, we;
      logic [L*DATA_W-1:0] d;
      v  = ($urandom_range(0, 3) != 0);
      fl = ($urandom_range(0, 39) == 0);
      we = ($urandom_range(0, 7) == 0);
      d  = (L*DATA_W)'({$urandom, $urandom});
      drive(v, d, fl, we, int'($urandom_range(0, TAPS - 1)),
            sext(longint'($urandom), COEF_W));
    end
    idle(5);
    check("drain_empty", longint'(q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
